i2c_target_regfile: RTL and testbench
=====================================

Name: i2c_target_regfile

Overview:
I2C target (responder) exposing an NREGS x 8-bit register file to an external I2C controller over an open-drain SCL/SDA bus.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a fixed 7-bit address and handles pointer-write, data-write and data-read transfers with auto-increment.
- Drives SDA low only, via sda_drive_en. It is the bus-side counterpart to the I2C controller and sits on the shared bus alongside other targets.

Parameters:
DEV_ADDR, 7'h42, 7-bit target address.
NREGS, 16, register count; power of 2, 2..256.
PW, $clog2(NREGS), pointer width (derived; do not override).

Ports:
clk  in  1  system clock; must be at least 8x the SCL frequency.
rst  in  1  asynchronous, active-low reset.
scl_in  in  1  raw SCL from the pad.
sda_in  in  1  raw SDA from the pad.
sda_drive_en  out  1  1 = pull SDA low; 0 = release. Never drives high.
busy  out  1  high from an address-matched START until STOP or loss of address match.
wr_strobe  out  1  one-cycle pulse per register written over I2C.
wr_addr  out  PW  index written (valid with wr_strobe).
wr_data  out  8  byte written (valid with wr_strobe).
host_raddr  in  PW  local read index.
host_rdata  out  8  regs[host_raddr], combinational.

Behaviour:
- Reset (rst=0, async): state=IDLE, regs=0, ptr=0, bitcnt=0, sda_drive_en=0, busy=0, wr_strobe=0, synchronizers=1.
- Synchronization and edge detection:
  - 2-FF synchronizer on scl_in and sda_in; 3rd stage kept for edge detection.
  - scl_rise/scl_fall = edges of synchronized SCL.
  - START = synchronized SDA falls while SCL=1.
  - STOP = synchronized SDA rises while SCL=1.
- Data timing:
  - Bits are sampled on scl_rise.
  - sda_drive_en changes only on scl_fall, except on START/STOP/reset, which release it immediately.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START in any state → ADDR, bitcnt=0, release SDA. This covers repeated START; ptr is retained.
- STOP in any state → IDLE, release SDA, busy=0.
- ADDR:
  - Shift 8 bits MSB first.
  - After the 8th rise: if addr[7:1]==DEV_ADDR, drive ACK (sda_drive_en=1) on the next scl_fall and go to ADDR_ACK with busy=1.
  - Otherwise go to WAIT_STOP with no ACK.
- ADDR_ACK:
  - On the scl_fall ending the ACK clock: if R/W=0, release SDA and go to PTR.
  - If R/W=1, load shift register with regs[ptr], drive bit7 (sda_drive_en = ~bit) and go to RDATA.
- PTR:
  - 8 bits received; ptr = byte[PW-1:0] (upper bits ignored).
  - ACK on the following clock via PTR_ACK, then WDATA.
- WDATA:
  - 8 bits received; write regs[ptr], pulse wr_strobe for one clk on the 8th scl_rise, ptr = ptr+1 mod NREGS.
  - ACK via WDATA_ACK, then back to WDATA.
- RDATA:
  - Shift out on each scl_fall.
  - After the 8th bit's scl_fall, release SDA and go to RDATA_ACK.
- RDATA_ACK:
  - Sample the controller's bit on scl_rise.
  - 0 (ACK): ptr++ mod NREGS; on scl_fall load regs[ptr] and drive bit7 (RDATA).
  - 1 (NACK): go to WAIT_STOP with SDA released.
- WAIT_STOP: ignore all bits; exit only on START/STOP.
- STOP/START mid-byte: partial byte discarded; no register write, no wr_strobe, no ptr change.
- Same-cycle conflicts:
  - If an I2C write and host_raddr target the same index in the same clk, host_rdata shows the old value that cycle.
  - START and STOP cannot coincide; START takes priority if both decode.
- busy deasserts on STOP, NACK or address mismatch.

Decomposition:
- Package i2c_target_pkg:
  - state enum typedef.
  - ACK=1'b0 and NACK=1'b1 constants.
  - function computing PW.
- Sub-module i2c_bus_sync: 2-FF synchronizers, SCL edge outputs, START/STOP detection. Reusable by the controller.

Test Plan:
- Write: START, 0x84, 0x03, 0xA5, 0x5A, STOP → ACK on all 4 bytes; regs[3]=A5, regs[4]=5A; two wr_strobe pulses with wr_addr 3 then 4; ptr=5.
- Read: START, 0x84, 0x03, repeated START, 0x85, then read 2 bytes (ACK, then NACK), STOP → SDA shows A5 then 5A; sda_drive_en=0 after NACK.
- Wrong address: START, 0xA0, 0x11, STOP → sda_drive_en stays 0 throughout; no wr_strobe; busy stays 0.
- Wrap: NREGS=16; write ptr 0x0F, data 0x11, 0x22 → regs[15]=0x11, regs[0]=0x22; ptr=1.
- Abort: STOP after 4 data bits of a write byte → no wr_strobe; register unchanged; state IDLE.
- Reset mid-read: assert rst while sda_drive_en=1 → sda_drive_en=0 in the same cycle (async); regs cleared; busy=0.

Source files
------------

// File: rtl/i2c_target_pkg.sv
// rtl/i2c_target_pkg.sv - shared types, constants and helpers for the I2C target register file
// Contents:
//   state_t  : target protocol state machine encoding
//   ACK/NACK : SDA level of the acknowledge bit
//   pw_of()  : pointer width for a power-of-2 register count (minimum 1)
package i2c_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  function automatic int pw_of(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 9; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/i2c_target_regfile_if.sv
// rtl/i2c_target_regfile_if.sv - open-drain I2C pad bundle between a target and the bus
// Signals:
//   scl_in       : raw SCL level seen at the pad
//   sda_in       : raw SDA level seen at the pad
//   sda_drive_en : 1 = target pulls SDA low, 0 = released (never driven high)
// Modports:
//   slave  : the target side (samples the pads, drives the pull-down enable)
//   master : the bus / pad side (presents levels, observes the pull-down enable)
interface i2c_target_regfile_if;

  logic scl_in;
  logic sda_in;
  logic sda_drive_en;

  modport slave (
    input  scl_in,
    input  sda_in,
    output sda_drive_en
  );

  modport master (
    output scl_in,
    output sda_in,
    input  sda_drive_en
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// rtl/i2c_bus_sync.sv - SCL/SDA synchronizers with SCL edge and START/STOP detection
// Ports:
//   clk, rst            : system clock, asynchronous active-low reset
//   scl_in, sda_in      : raw pad levels
//   sda                 : synchronized SDA (the value to sample on scl_rise)
//   scl_rise, scl_fall  : one-cycle pulses on synchronized SCL edges
//   start_det, stop_det : one-cycle pulses on SDA fall / rise while SCL is high
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0],[1] form the 2-FF synchronizer; [2] is the previous synchronized value.
  logic [2:0] scl_sr;
  logic [2:0] sda_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_in};
      sda_sr <= {sda_sr[1:0], sda_in};
    end
  end

  assign sda      = sda_sr[1];
  assign scl_rise =  scl_sr[1] & ~scl_sr[2];
  assign scl_fall = ~scl_sr[1] &  scl_sr[2];

  // SCL must be high in both compared samples so an SDA change made right
  // around an SCL edge is never mistaken for a bus condition.
  assign start_det = scl_sr[1] & scl_sr[2] &  sda_sr[2] & ~sda_sr[1];
  assign stop_det  = scl_sr[1] & scl_sr[2] & ~sda_sr[2] &  sda_sr[1];

endmodule

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing an NREGS x 8-bit register file
// Ports:
//   clk, rst         : system clock (>= 8x SCL), asynchronous active-low reset
//   bus              : pad bundle (scl_in, sda_in in; sda_drive_en out)
//   busy             : address-matched transfer in progress
//   wr_strobe        : one-cycle pulse per register written over I2C
//   wr_addr, wr_data : index and byte written, valid with wr_strobe
//   host_raddr       : local read index
//   host_rdata       : regs[host_raddr], combinational
module i2c_target_regfile
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h42,
  parameter int         NREGS    = 16,
  parameter int         PW       = pw_of(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  i2c_target_regfile_if.slave bus,
  output logic              busy,
  output logic              wr_strobe,
  output logic [PW-1:0]     wr_addr,
  output logic [7:0]        wr_data,
  input  logic [PW-1:0]     host_raddr,
  output logic [7:0]        host_rdata
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (bus.scl_in),
    .sda_in    (bus.sda_in),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t        state, state_n;
  logic [2:0]    bitcnt, bitcnt_n;
  logic [7:0]    shreg, shreg_n;
  logic [PW-1:0] ptr, ptr_n;
  logic          rw, rw_n;
  logic          drive, drive_n;
  logic          busy_n, strobe_n;
  logic [PW-1:0] waddr_n;
  logic [7:0]    wdata_n;
  logic          reg_we;
  logic [7:0]    regs [NREGS];
  logic [7:0]    rx_byte;
  logic [7:0]    rd_byte;

  // Byte as it stands once the bit on the current SCL rise is shifted in.
  assign rx_byte = {shreg[6:0], sda_s};
  assign rd_byte = regs[ptr];

  assign bus.sda_drive_en = drive;
  assign host_rdata       = regs[host_raddr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      ptr       <= '0;
      rw        <= 1'b0;
      drive     <= 1'b0;
      busy      <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shreg     <= shreg_n;
      ptr       <= ptr_n;
      rw        <= rw_n;
      drive     <= drive_n;
      busy      <= busy_n;
      wr_strobe <= strobe_n;
      wr_addr   <= waddr_n;
      wr_data   <= wdata_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (reg_we) begin
      regs[ptr] <= rx_byte;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    ptr_n    = ptr;
    rw_n     = rw;
    drive_n  = drive;
    busy_n   = busy;
    strobe_n = 1'b0;
    waddr_n  = wr_addr;
    wdata_n  = wr_data;
    reg_we   = 1'b0;

    if (start_det) begin
      // Also the repeated-START path: the pointer is deliberately kept.
      state_n  = ADDR;
      bitcnt_n = '0;
      drive_n  = 1'b0;
    end else if (stop_det) begin
      state_n  = IDLE;
      bitcnt_n = '0;
      drive_n  = 1'b0;
      busy_n   = 1'b0;
    end else begin
      case (state)
        IDLE: ;

        ADDR: begin
          if (scl_rise) begin
            shreg_n  = rx_byte;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              rw_n = sda_s;
              if (rx_byte[7:1] == DEV_ADDR) begin
                state_n = ADDR_ACK;
                busy_n  = 1'b1;
              end else begin
                state_n = WAIT_STOP;
                busy_n  = 1'b0;
              end
            end
          end
        end

        // In the ACK states the drive flag doubles as the phase marker:
        // the first fall starts the ACK bit, the second fall ends it.
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!drive) begin
              drive_n = 1'b1;
            end else if (!rw) begin
              drive_n  = 1'b0;
              state_n  = PTR;
              bitcnt_n = '0;
            end else begin
              shreg_n  = rd_byte;
              drive_n  = ~rd_byte[7];
              state_n  = RDATA;
              bitcnt_n = '0;
            end
          end
        end

        PTR: begin
          if (scl_rise) begin
            shreg_n  = rx_byte;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              ptr_n   = rx_byte[PW-1:0];
              state_n = PTR_ACK;
            end
          end
        end

        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!drive) begin
              drive_n = 1'b1;
            end else begin
              drive_n  = 1'b0;
              state_n  = WDATA;
              bitcnt_n = '0;
            end
          end
        end

        WDATA: begin
          if (scl_rise) begin
            shreg_n  = rx_byte;
            bitcnt_n = bitcnt + 3'd1;
            if (bitcnt == 3'd7) begin
              reg_we   = 1'b1;
              strobe_n = 1'b1;
              waddr_n  = ptr;
              wdata_n  = rx_byte;
              ptr_n    = ptr + 1'b1;
              state_n  = WDATA_ACK;
            end
          end
        end

        // Bit 7 is already on the bus when this state is entered, so each
        // fall presents the next bit; the eighth fall hands SDA back.
        RDATA: begin
          if (scl_fall) begin
            if (bitcnt == 3'd7) begin
              drive_n  = 1'b0;
              state_n  = RDATA_ACK;
              bitcnt_n = '0;
            end else begin
              shreg_n  = {shreg[6:0], 1'b0};
              drive_n  = ~shreg[6];
              bitcnt_n = bitcnt + 3'd1;
            end
          end
        end

        // A fall is only reachable here after an ACKed rise, by which time
        // ptr has already advanced to the next register.
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK) begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end else if (sda_s == ACK) begin
              ptr_n = ptr + 1'b1;
            end
          end else if (scl_fall) begin
            shreg_n  = rd_byte;
            drive_n  = ~rd_byte[7];
            state_n  = RDATA;
            bitcnt_n = '0;
          end
        end

        WAIT_STOP: ;

        default: begin
          state_n = IDLE;
          drive_n = 1'b0;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;

  localparam int NREGS = 16;
  localparam int PW    = 4;
  localparam int Q     = 50;

  typedef struct {
    logic [PW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic scl_m = 1'b1;
  logic sda_m = 1'b1;

  i2c_target_regfile_if bus ();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_drive_en;

  logic          busy, wr_strobe;
  logic [PW-1:0] wr_addr;
  logic [PW-1:0] host_raddr = '0;
  logic [7:0]    wr_data, host_rdata;

  i2c_target_regfile #(.DEV_ADDR(7'h42), .NREGS(NREGS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_raddr (host_raddr),
    .host_rdata (host_rdata)
  );

  int            errors = 0;
  int            checks = 0;
  logic [7:0]    model_regs [NREGS];
  logic [PW-1:0] model_ptr = '0;
  wr_t           wr_q [$];
  logic [7:0]    rd_q [$];
  int            strobe_cnt = 0;
  logic          drive_seen = 1'b0;
  logic          busy_seen = 1'b0;
  wr_t           exp_w;

  always @(negedge clk) begin
    if (bus.sda_drive_en) drive_seen = 1'b1;
    if (busy) busy_seen = 1'b1;
    if (rst && wr_strobe) begin
      strobe_cnt++;
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_strobe_unexpected: got addr=%0d data=%02h, no write expected", wr_addr, wr_data);
      end else begin
        exp_w = wr_q.pop_front();
        if (wr_addr !== exp_w.a || wr_data !== exp_w.d) begin
          errors++;
          $display("FAIL wr_strobe_value: got addr=%0d data=%02h, expected addr=%0d data=%02h",
                   wr_addr, wr_data, exp_w.a, exp_w.d);
        end
      end
    end
  end

  task automatic send_start();
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b0; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic send_stop();
    sda_m = 1'b0; #(Q);
    scl_m = 1'b1; #(Q);
    sda_m = 1'b1; #(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; #(Q);
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; #(Q);
    scl_m = 1'b1; #(Q);
    b = bus.sda_in; #(Q);
    scl_m = 1'b0; #(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic send_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(send_ack ? 1'b0 : 1'b1);
  endtask

  task automatic do_write(input string tag, input logic [7:0] p, input logic [7:0] data [$]);
    logic a;
    wr_t  e;
    send_start();
    write_byte(8'h84, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL %s_addr_ack: got %b, expected 0", tag, a); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s_busy_on: got %b, expected 1", tag, busy); end
    write_byte(p, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL %s_ptr_ack: got %b, expected 0", tag, a); end
    model_ptr = p[PW-1:0];
    foreach (data[k]) begin
      e.a = model_ptr;
      e.d = data[k];
      wr_q.push_back(e);
      model_regs[model_ptr] = data[k];
      model_ptr = model_ptr + 1'b1;
      write_byte(data[k], a);
      checks++;
      if (a !== 1'b0) begin errors++; $display("FAIL %s_data%0d_ack: got %b, expected 0", tag, k, a); end
    end
    send_stop();
    #(4*Q);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_off: got %b, expected 0", tag, busy); end
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL %s_missing_strobe: got %0d pending, expected 0", tag, wr_q.size()); end
  endtask

  task automatic read_cur(input string tag, input int n);
    logic       a;
    logic       last;
    logic [7:0] got, exp;
    send_start();
    write_byte(8'h85, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL %s_rd_addr_ack: got %b, expected 0", tag, a); end
    for (int k = 0; k < n; k++) begin
      rd_q.push_back(model_regs[model_ptr]);
      last = (k == n - 1);
      read_byte(got, !last);
      exp = rd_q.pop_front();
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s_rd_byte%0d: got %02h, expected %02h", tag, k, got, exp); end
      if (!last) model_ptr = model_ptr + 1'b1;
    end
    #(2*Q);
    checks++;
    if (bus.sda_drive_en !== 1'b0) begin errors++; $display("FAIL %s_release_after_nack: got %b, expected 0", tag, bus.sda_drive_en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL %s_busy_after_nack: got %b, expected 0", tag, busy); end
    send_stop();
    #(2*Q);
  endtask

  task automatic test_reset();
    checks++;
    if (bus.sda_drive_en !== 1'b0) begin errors++; $display("FAIL reset_drive: got %b, expected 0", bus.sda_drive_en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    checks++;
    if (wr_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe: got %b, expected 0", wr_strobe); end
    for (int i = 0; i < NREGS; i += 5) begin
      host_raddr = i[PW-1:0];
      #1;
      checks++;
      if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_reg%0d: got %02h, expected 00", i, host_rdata); end
    end
  endtask

  task automatic test_write();
    logic [7:0] dq [$];
    dq.delete(); dq.push_back(8'hC3);
    do_write("preload5", 8'h05, dq);
    dq.delete(); dq.push_back(8'hA5); dq.push_back(8'h5A);
    do_write("write", 8'h03, dq);
    for (int i = 3; i <= 5; i++) begin
      host_raddr = i[PW-1:0];
      #1;
      checks++;
      if (host_rdata !== model_regs[i]) begin errors++; $display("FAIL write_reg%0d: got %02h, expected %02h", i, host_rdata, model_regs[i]); end
    end
    read_cur("write_ptr", 1);
  endtask

  task automatic test_read();
    logic a;
    send_start();
    write_byte(8'h84, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL read_addr_ack: got %b, expected 0", a); end
    write_byte(8'h03, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL read_ptr_ack: got %b, expected 0", a); end
    model_ptr = 4'd3;
    read_cur("read", 2);
  endtask

  task automatic test_wrong_addr();
    logic a;
    int   s0;
    s0 = strobe_cnt;
    drive_seen = 1'b0;
    busy_seen  = 1'b0;
    send_start();
    write_byte(8'hA0, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL wrong_addr_ack: got %b, expected 1", a); end
    write_byte(8'h11, a);
    checks++;
    if (a !== 1'b1) begin errors++; $display("FAIL wrong_data_ack: got %b, expected 1", a); end
    send_stop();
    #(2*Q);
    checks++;
    if (drive_seen !== 1'b0) begin errors++; $display("FAIL wrong_drive_seen: got %b, expected 0", drive_seen); end
    checks++;
    if (busy_seen !== 1'b0) begin errors++; $display("FAIL wrong_busy_seen: got %b, expected 0", busy_seen); end
    checks++;
    if (strobe_cnt != s0) begin errors++; $display("FAIL wrong_strobes: got %0d, expected %0d", strobe_cnt - s0, 0); end
  endtask

  task automatic test_wrap();
    logic [7:0] dq [$];
    dq.delete(); dq.push_back(8'h99); dq.push_back(8'h98);
    do_write("preload1", 8'h01, dq);
    dq.delete(); dq.push_back(8'h11); dq.push_back(8'h22);
    do_write("wrap", 8'h0F, dq);
    host_raddr = 4'd15;
    #1;
    checks++;
    if (host_rdata !== 8'h11) begin errors++; $display("FAIL wrap_reg15: got %02h, expected 11", host_rdata); end
    host_raddr = 4'd0;
    #1;
    checks++;
    if (host_rdata !== 8'h22) begin errors++; $display("FAIL wrap_reg0: got %02h, expected 22", host_rdata); end
    read_cur("wrap_ptr", 1);
  endtask

  task automatic test_abort();
    logic a;
    int   s0;
    s0 = strobe_cnt;
    send_start();
    write_byte(8'h84, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL abort_addr_ack: got %b, expected 0", a); end
    write_byte(8'h02, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL abort_ptr_ack: got %b, expected 0", a); end
    model_ptr = 4'd2;
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    send_stop();
    #(2*Q);
    checks++;
    if (strobe_cnt != s0) begin errors++; $display("FAIL abort_strobes: got %0d, expected 0", strobe_cnt - s0); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    host_raddr = 4'd2;
    #1;
    checks++;
    if (host_rdata !== model_regs[2]) begin errors++; $display("FAIL abort_reg2: got %02h, expected %02h", host_rdata, model_regs[2]); end
    read_cur("abort_ptr", 1);
  endtask

  task automatic test_reset_mid_read();
    logic       a;
    logic [7:0] dq [$];
    dq.delete(); dq.push_back(8'h3C);
    do_write("preload7", 8'h07, dq);
    send_start();
    write_byte(8'h84, a);
    write_byte(8'h07, a);
    send_start();
    write_byte(8'h85, a);
    checks++;
    if (a !== 1'b0) begin errors++; $display("FAIL rstmid_addr_ack: got %b, expected 0", a); end
    checks++;
    if (bus.sda_drive_en !== 1'b1) begin errors++; $display("FAIL rstmid_driving: got %b, expected 1", bus.sda_drive_en); end
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.sda_drive_en !== 1'b0) begin errors++; $display("FAIL rstmid_async_release: got %b, expected 0", bus.sda_drive_en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, expected 0", busy); end
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    model_ptr = '0;
    for (int i = 1; i < 8; i += 2) begin
      host_raddr = i[PW-1:0];
      #1;
      checks++;
      if (host_rdata !== 8'h00) begin errors++; $display("FAIL rstmid_reg%0d: got %02h, expected 00", i, host_rdata); end
    end
    scl_m = 1'b1;
    sda_m = 1'b1;
    #(40);
    rst = 1'b1;
    #(2*Q);
    read_cur("post_reset", 1);
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
    #20;
    rst = 1'b1;
    #40;
    test_reset();
    test_write();
    test_read();
    test_wrong_addr();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    checks++;
    if (wr_q.size() != 0) begin errors++; $display("FAIL final_pending_writes: got %0d, expected 0", wr_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
